// File: rtl/dfd_rr_req_arbiter.sv
// Round-robin request arbiter: one holding slot per source, LSB-first rotating priority,
// and a registered valid/ready output stage feeding the shared downstream sink.
module dfd_rr_req_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                out_valid,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [IDX_W-1:0]                    out_idx,
    input  logic                                out_ready
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // valid never depends on ready; ready may depend on valid-independent state only.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]                 slot_vld;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slot_data;
    logic [IDX_W-1:0]                   last_ptr;

    logic                               load;
    logic                               any_pending;
    logic [NUM_REQ-1:0]                 mask_hi;
    logic [NUM_REQ-1:0]                 cand;
    logic                               any_hi;
    logic [IDX_W-1:0]                   win_hi;
    logic [IDX_W-1:0]                   win_lo;
    logic [IDX_W-1:0]                   winner;
    logic [NUM_REQ-1:0]                 grant;

    assign load        = ~out_valid | out_ready;
    assign any_pending = |slot_vld;
    assign cand        = slot_vld & mask_hi;
    assign any_hi      = |cand;
    assign winner      = any_hi ? win_hi : win_lo;

    // Descending scans so the last hit written is the lowest set bit.
    always_comb begin
        mask_hi = '0;
        win_hi  = '0;
        win_lo  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            mask_hi[i] = (IDX_W'(i) > last_ptr);
            if (slot_vld[i] && (IDX_W'(i) > last_ptr)) win_hi = IDX_W'(i);
            if (slot_vld[i]) win_lo = IDX_W'(i);
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = load & any_pending & (winner == IDX_W'(i));
        end
    end

    assign req_ready = {NUM_REQ{~flush}} & (~slot_vld | grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld  <= '0;
            slot_data <= '0;
            last_ptr  <= LAST_IDX;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (flush) begin
            slot_vld  <= '0;
            last_ptr  <= LAST_IDX;
            out_valid <= 1'b0;
        end else begin
            // A refill on the same edge as a grant wins, keeping the slot occupied.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_data[i] <= req_data[i];
                end else if (grant[i]) begin
                    slot_vld[i]  <= 1'b0;
                end
            end
            if (load) begin
                if (any_pending) begin
                    out_valid <= 1'b1;
                    out_data  <= slot_data[winner];
                    out_idx   <= winner;
                    last_ptr  <= winner;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
